demux_dispatch_ctrl: RTL

DEMUX_DISPATCH_CTRL -- requirements
Module: demux_dispatch_ctrl

---
 rtl/demux_dispatch_ctrl.sv | 137 +++++++++++++
 1 files changed

// File: rtl/demux_dispatch_ctrl.sv
// demux_dispatch_ctrl: routes a single upstream word stream to one of four
// downstream lanes, either by explicit lane select or round-robin. One word is
// held at a time. A held word that stalls for TIMEOUT cycles is dropped.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   mode                  0 = addressed (in_sel), 1 = round-robin
//   in_sel                target lane for addressed mode
//   in_data/in_valid      upstream word and its valid
//   in_ready              upstream accept (combinational)
//   out_data              four lanes, lane k at [k*WIDTH +: WIDTH]
//   out_valid/out_ready   per-lane handshake; out_valid is one-hot or zero
//   cur_sel               lane of held word, or next round-robin lane when idle
//   busy                  a word is held
//   drop                  one-cycle pulse when a held word times out
module demux_dispatch_ctrl #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mode,
    input  logic [1:0]           in_sel,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [4*WIDTH-1:0]   out_data,
    output logic [3:0]           out_valid,
    input  logic [3:0]           out_ready,
    output logic [1:0]           cur_sel,
    output logic                 busy,
    output logic                 drop
);

    localparam int unsigned LANES   = 4;
    localparam int unsigned CNT_W   = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W:0]   TIMEOUT_W  = (CNT_W+1)'(TIMEOUT);
    localparam logic             TIMEOUT_EN = (TIMEOUT != 0);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     data_q, data_d;
    logic [1:0]           tgt_q, tgt_d;
    logic [1:0]           rr_q, rr_d;
    logic                 rr_word_q, rr_word_d;   // held word was captured in round-robin mode
    logic [CNT_W-1:0]     stall_q, stall_d;
    logic                 drop_d;
    logic                 down_xfer, up_xfer, timeout_hit;
    logic [3:0]           out_valid_d;
    logic [4*WIDTH-1:0]   out_data_d;
    logic [1:0]           cur_sel_d;
    logic                 busy_d;

    // Handshake decode and next-state / next-output computation
    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        tgt_d     = tgt_q;
        rr_word_d = rr_word_q;
        stall_d   = stall_q;
        drop_d    = 1'b0;

        in_ready    = (state_q == IDLE) || out_ready[tgt_q];
        down_xfer   = (state_q == SEND) && out_ready[tgt_q];
        up_xfer     = in_valid && in_ready;
        // Drop when this stalled cycle brings the counter up to TIMEOUT
        timeout_hit = TIMEOUT_EN && (state_q == SEND) && !out_ready[tgt_q] &&
                      (({1'b0, stall_q} + (CNT_W+1)'(1)) == TIMEOUT_W);

        // Pointer advances before a same-cycle capture so back-to-back words rotate
        rr_d = rr_q + 2'(down_xfer && rr_word_q);

        if (up_xfer) begin
            state_d   = SEND;
            data_d    = in_data;
            tgt_d     = mode ? rr_d : in_sel;
            rr_word_d = mode;
            stall_d   = '0;
        end else if (down_xfer) begin
            state_d = IDLE;
        end else if (state_q == SEND) begin
            stall_d = (stall_q == CNT_MAX) ? stall_q : stall_q + CNT_W'(1);
            if (timeout_hit) begin
                state_d = IDLE;
                drop_d  = 1'b1;
            end
        end

        out_valid_d = '0;
        out_data_d  = '0;
        if (state_d == SEND) begin
            out_valid_d = 4'(1) << tgt_d;
        end
        for (int unsigned k = 0; k < LANES; k++) begin
            if ((state_d == SEND) && (tgt_d == 2'(k))) begin
                out_data_d[k*WIDTH +: WIDTH] = data_d;
            end
        end
        busy_d    = (state_d == SEND);
        cur_sel_d = (state_d == SEND) ? tgt_d : rr_d;
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            data_q    <= '0;
            tgt_q     <= '0;
            rr_q      <= '0;
            rr_word_q <= 1'b0;
            stall_q   <= '0;
            out_valid <= '0;
            out_data  <= '0;
            cur_sel   <= '0;
            busy      <= 1'b0;
            drop      <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            tgt_q     <= tgt_d;
            rr_q      <= rr_d;
            rr_word_q <= rr_word_d;
            stall_q   <= stall_d;
            out_valid <= out_valid_d;
            out_data  <= out_data_d;
            cur_sel   <= cur_sel_d;
            busy      <= busy_d;
            drop      <= drop_d;
        end
    end

endmodule
